line_fill_responder: RTL
========================

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 Parameter WORD_INDEX_BITS, default 3, log2 words per cache line (8 words).
REQ-002 Parameter LATENCY, default 2, idle cycles inserted between request acceptance and first SRAM read; range 0..15.
REQ-003 Parameter ADDR_BITS, default 30, word-address width.
REQ-004 clock  input  1  sole clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 imem_read  input  1  line-fill request from the instruction fetch stage; held high until accepted.
REQ-007 imem_address  input  ADDR_BITS  word address of the requested line; sampled on acceptance.
REQ-008 imem_waitrequest  output  1  registered; high means request not accepted this cycle.
REQ-009 imem_readdata  output  32  returned instruction word.
REQ-010 imem_readdatavalid  output  1  registered; imem_readdata valid this cycle.
REQ-011 sram_address  output  ADDR_BITS  word address to backing synchronous SRAM.
REQ-012 sram_read  output  1  SRAM read strobe; data returns exactly one cycle later.
REQ-013 sram_readdata  input  32  SRAM read data, valid the cycle after sram_read.

Function
REQ-014 States: S_IDLE, S_WAIT, S_STREAM, S_DRAIN; one request outstanding at a time.
REQ-015 imem_waitrequest SHALL be 0 only in S_IDLE; a request is accepted in cycle T when imem_read=1 and state is S_IDLE.
REQ-016 On acceptance: latch line base = imem_address[ADDR_BITS-1:WORD_INDEX_BITS], start word = imem_address[WORD_INDEX_BITS-1:0], load wait counter with LATENCY, go S_WAIT (or S_STREAM directly if LATENCY=0).
REQ-017 S_WAIT: decrement counter each cycle; on reaching zero go S_STREAM so that the first sram_read is in cycle T+LATENCY+1.
REQ-018 S_STREAM: assert sram_read every cycle for exactly 2^WORD_INDEX_BITS consecutive cycles; sram_address = {line base, word index}.
REQ-019 Word index starts at start word and increments modulo 2^WORD_INDEX_BITS (wraps within the line; upper bits never change).
REQ-020 imem_readdatavalid SHALL be asserted the cycle after each sram_read, with imem_readdata = sram_readdata registered through; no gaps within a burst.
REQ-021 After the last sram_read go S_DRAIN for one cycle (last readdatavalid), then S_IDLE; with defaults, last readdatavalid at T+11, waitrequest low again at T+12.
REQ-022 imem_read high while waitrequest high SHALL be ignored (no queuing); the requester must hold it until S_IDLE.
REQ-023 imem_readdatavalid SHALL never be asserted in S_IDLE or S_WAIT except the S_DRAIN-to-S_IDLE boundary as per REQ-021.
REQ-024 Exactly 2^WORD_INDEX_BITS readdatavalid pulses per accepted request; never more, never fewer.
REQ-025 imem_address low bits nonzero is legal: words return in wrapped order starting at the requested word.
REQ-026 imem_readdata SHALL hold its last value when readdatavalid is low.

Reset
REQ-027 reset_n low asynchronously forces: state S_IDLE, imem_waitrequest 0, imem_readdatavalid 0, sram_read 0, imem_readdata 0, sram_address 0, counters 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; no further readdatavalid pulses after reset release until a new request is accepted.
REQ-029 First request may be accepted in the first rising edge after reset_n deasserts.

Verification
REQ-030 Defaults; request address 0x0000_0040 at T -> sram_read T+3..T+10 addresses 0x40..0x47; readdatavalid T+4..T+11 with SRAM words in order; waitrequest low at T+12.
REQ-031 Request address 0x0000_0045 -> SRAM addresses 0x45,0x46,0x47,0x40,0x41,0x42,0x43,0x44; 8 valid words in that order.
REQ-032 LATENCY=0; request at T -> first sram_read T+1, first readdatavalid T+2, last T+9, waitrequest low T+10.
REQ-033 Hold imem_read high continuously across two bursts -> second request accepted at first S_IDLE cycle; exactly 16 readdatavalid pulses total; no overlap between bursts.
REQ-034 Pulse reset_n low at T+6 during burst -> waitrequest 0, readdatavalid 0, sram_read 0 immediately; after release no valid pulses until new request.
REQ-035 Back-to-back with the fetch stage: miss at pc 0x0000_1000 -> all 8 line words written to cache, tag updated, fetch resumes with correct instruction.

Source files
------------

// File: rtl/line_fill_responder.sv
// Line-fill responder: accepts one instruction-fetch line request at a time,
// waits LATENCY cycles, then streams a full cache line from a synchronous SRAM
// in wrapped order starting at the requested word.
module line_fill_responder #(
  parameter int unsigned WORD_INDEX_BITS = 3,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned ADDR_BITS       = 30
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 imem_read,
  input  logic [ADDR_BITS-1:0] imem_address,
  output logic                 imem_waitrequest,
  output logic [31:0]          imem_readdata,
  output logic                 imem_readdatavalid,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic                 sram_read,
  input  logic [31:0]          sram_readdata
);

  localparam int unsigned BASE_BITS = ADDR_BITS - WORD_INDEX_BITS;
  localparam int unsigned CNT_BITS  = 4;
  localparam logic [CNT_BITS-1:0] LAT_LOAD = CNT_BITS'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                     state, state_d;
  logic [BASE_BITS-1:0]       line_base, line_base_d;
  logic [WORD_INDEX_BITS-1:0] word_idx, word_idx_d;
  logic [WORD_INDEX_BITS-1:0] beat_cnt, beat_cnt_d;
  logic [CNT_BITS-1:0]        wait_cnt, wait_cnt_d;
  logic [31:0]                data_hold, data_hold_d;
  logic [ADDR_BITS-1:0]       sram_address_d;
  logic                       sram_read_d;
  logic                       waitrequest_d;
  logic                       readdatavalid_d;

  logic                       accept;
  logic [BASE_BITS-1:0]       base_src;
  logic [WORD_INDEX_BITS-1:0] idx_src;

  assign accept = (state == S_IDLE) && imem_read;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (imem_read) begin
          state_d = (LAT_LOAD == '0) ? S_STREAM : S_WAIT;
        end
      end
      S_WAIT: begin
        // Leave one cycle early so the registered read strobe lands on T+LATENCY+1
        if (wait_cnt <= CNT_BITS'(1)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_cnt == '1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    line_base_d     = line_base;
    word_idx_d      = word_idx;
    beat_cnt_d      = beat_cnt;
    wait_cnt_d      = wait_cnt;
    sram_address_d  = sram_address;
    sram_read_d     = 1'b0;
    waitrequest_d   = (state_d != S_IDLE);
    readdatavalid_d = sram_read;
    data_hold_d     = imem_readdatavalid ? sram_readdata : data_hold;

    // With zero latency the first read address comes straight from the request
    base_src = accept ? imem_address[ADDR_BITS-1:WORD_INDEX_BITS] : line_base;
    idx_src  = accept ? imem_address[WORD_INDEX_BITS-1:0] : word_idx;

    if (accept) begin
      line_base_d = imem_address[ADDR_BITS-1:WORD_INDEX_BITS];
      word_idx_d  = imem_address[WORD_INDEX_BITS-1:0];
      wait_cnt_d  = LAT_LOAD;
      beat_cnt_d  = '0;
    end

    if (state == S_WAIT) begin
      wait_cnt_d = wait_cnt - CNT_BITS'(1);
    end

    if (state == S_STREAM) begin
      beat_cnt_d = beat_cnt + WORD_INDEX_BITS'(1);
    end

    // Issue the next read of the line; the index wraps inside the line
    if (state_d == S_STREAM) begin
      sram_read_d    = 1'b1;
      sram_address_d = {base_src, idx_src};
      word_idx_d     = idx_src + WORD_INDEX_BITS'(1);
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_base          <= '0;
      word_idx           <= '0;
      beat_cnt           <= '0;
      wait_cnt           <= '0;
      data_hold          <= '0;
      sram_address       <= '0;
      sram_read          <= 1'b0;
      imem_waitrequest   <= 1'b0;
      imem_readdatavalid <= 1'b0;
    end else begin
      line_base          <= line_base_d;
      word_idx           <= word_idx_d;
      beat_cnt           <= beat_cnt_d;
      wait_cnt           <= wait_cnt_d;
      data_hold          <= data_hold_d;
      sram_address       <= sram_address_d;
      sram_read          <= sram_read_d;
      imem_waitrequest   <= waitrequest_d;
      imem_readdatavalid <= readdatavalid_d;
    end
  end

  // SRAM data arrives the cycle after the strobe, aligned with the valid flag;
  // between beats the last delivered word is held.
  assign imem_readdata = imem_readdatavalid ? sram_readdata : data_hold;

endmodule
